// File: rtl/alu_cmd_master_pkg.sv
// Shared widths, ALU mode codes and FSM state encoding for the ALU command master.
package alu_pkg;

  localparam int ALU_W     = 32;
  localparam int ALU_OUT_W = 64;

  localparam logic [1:0] MODE_MUL   = 2'd0;
  localparam logic [1:0] MODE_DIV   = 2'd1;
  localparam logic [1:0] MODE_SHIFT = 2'd2;
  localparam logic [1:0] MODE_AVG   = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic [1:0]       mode;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_master_if.sv
// Command, ALU-issue and response signals of the ALU command master, with DUT/environment views.
interface alu_cmd_master_if;
  import alu_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_mode;
  logic [ALU_W-1:0]     cmd_a;
  logic [ALU_W-1:0]     cmd_b;
  logic                 alu_valid;
  logic [1:0]           alu_mode;
  logic [ALU_W-1:0]     alu_a;
  logic [ALU_W-1:0]     alu_b;
  logic                 alu_ready;
  logic [ALU_OUT_W-1:0] alu_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_mode;
  logic [ALU_OUT_W-1:0] rsp_data;
  logic                 rsp_err;

  modport master (
    input  cmd_valid, cmd_mode, cmd_a, cmd_b, alu_ready, alu_out, rsp_ready,
    output cmd_ready, alu_valid, alu_mode, alu_a, alu_b, rsp_valid, rsp_mode, rsp_data, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_a, cmd_b, alu_ready, alu_out, rsp_ready,
    input  cmd_ready, alu_valid, alu_mode, alu_a, alu_b, rsp_valid, rsp_mode, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_cmd_master_fifo.sv
// Synchronous command FIFO holding {mode,a,b}; no write-to-read bypass, pointers flushed on reset.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t         mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_cmd_master.sv
// ALU command master: buffers commands, issues one ALU op at a time, returns result or timeout error.
// Optional macro ALU_MASTER_DIV0_GUARD_EN answers DIV-by-zero locally without issuing it.
module alu_cmd_master
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_master_if.master  bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic             rdy_en;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             div0;
  cmd_t             head;
  cmd_t             cmd_in;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cur_mode;

  logic                 alu_valid_q;
  logic [1:0]           alu_mode_q;
  logic [ALU_W-1:0]     alu_a_q;
  logic [ALU_W-1:0]     alu_b_q;
  logic                 rsp_valid_q;
  logic [1:0]           rsp_mode_q;
  logic [ALU_OUT_W-1:0] rsp_data_q;
  logic                 rsp_err_q;

  // Holds cmd_ready low through reset and releases it the cycle after.
  always_ff @(posedge clk) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign bus.cmd_ready = rdy_en & ~full;
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign pop           = (state == ST_IDLE) & ~empty;
  assign cmd_in        = '{mode: bus.cmd_mode, a: bus.cmd_a, b: bus.cmd_b};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

`ifdef ALU_MASTER_DIV0_GUARD_EN
  assign div0 = (head.mode == MODE_DIV) && (head.b == '0);
`else
  assign div0 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (pop) cur_mode <= head.mode;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      alu_valid_q <= 1'b0;
      alu_mode_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_mode_q  <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            if (div0) begin
              rsp_valid_q <= 1'b1;
              rsp_mode_q  <= head.mode;
              rsp_data_q  <= '1;
              rsp_err_q   <= 1'b1;
              state       <= ST_RESP;
            end else begin
              alu_valid_q <= 1'b1;
              alu_mode_q  <= head.mode;
              alu_a_q     <= head.a;
              alu_b_q     <= head.b;
              state       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          alu_valid_q <= 1'b0;
          alu_mode_q  <= '0;
          alu_a_q     <= '0;
          alu_b_q     <= '0;
          cnt         <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // Ready is tested before the timeout so a result in the final cycle still wins.
          if (bus.alu_ready) begin
            rsp_valid_q <= 1'b1;
            rsp_mode_q  <= cur_mode;
            rsp_data_q  <= bus.alu_out;
            rsp_err_q   <= 1'b0;
            state       <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_mode_q  <= cur_mode;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_mode_q  <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            state       <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.alu_valid = alu_valid_q;
  assign bus.alu_mode  = alu_mode_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_mode  = rsp_mode_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Self-checking bench for alu_cmd_master: ALU stand-in with mode-dependent latency, response scoreboard.
module tb_alu_cmd_master;
  import alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_master_if bus();

  alu_cmd_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [1:0] mode; logic [63:0] data; logic err; } rsp_t;
  typedef struct { logic [1:0] mode; logic [31:0] a; logic [31:0] b; } iss_t;

  rsp_t exp_q[$];
  iss_t iss_q[$];

  int errors = 0;
  int checks = 0;
  int issued = 0;
  int exp_issued = 0;
  bit bad_issue = 1'b0;
  bit prev_valid = 1'b0;
  bit never_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] alu_ref(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      2'd0:    return 64'(a) * 64'(b);
      2'd1:    return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      2'd2:    return {32'h0, a >> b[4:0]};
      default: return 64'((33'(a) + 33'(b)) >> 1);
    endcase
  endfunction

  // ALU stand-in: MUL/DIV answer 32 cycles after the issue pulse, SHIFT/AVG after 1.
  int          rem = 0;
  logic [63:0] pend = '0;
  always @(negedge clk) begin
    if (bus.alu_valid) begin
      rem  = (bus.alu_mode == MODE_MUL || bus.alu_mode == MODE_DIV) ? 32 : 1;
      pend = alu_ref(bus.alu_mode, bus.alu_a, bus.alu_b);
      bus.alu_ready = 1'b0;
      bus.alu_out   = '0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0 && !never_ready) begin
        bus.alu_ready = 1'b1;
        bus.alu_out   = pend;
      end else begin
        bus.alu_ready = 1'b0;
        bus.alu_out   = '0;
      end
    end else begin
      bus.alu_ready = 1'b0;
      bus.alu_out   = '0;
    end
  end

  // Issue monitor: each pulse must match the next expected command and last one cycle.
  always @(negedge clk) begin
    if (bus.alu_valid) begin
      issued++;
      if (prev_valid) bad_issue = 1'b1;
      if (iss_q.size() == 0) begin
        bad_issue = 1'b1;
      end else begin
        iss_t e;
        e = iss_q.pop_front();
        check("issue_mode", 64'(bus.alu_mode), 64'(e.mode));
        check("issue_a", 64'(bus.alu_a), 64'(e.a));
        check("issue_b", 64'(bus.alu_b), 64'(e.b));
      end
    end else if (bus.alu_mode != 0 || bus.alu_a != 0 || bus.alu_b != 0) begin
      bad_issue = 1'b1;
    end
    prev_valid = bus.alu_valid;
  end

  // kind: 0 normal, 1 timeout, 2 guarded DIV-by-0 (not issued), 3 abandoned by reset
  task automatic expect_cmd(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b, input int kind);
    rsp_t r;
    r.mode = m;
    r.err  = (kind == 1 || kind == 2);
    r.data = (kind == 1) ? 64'h0 : (kind == 2) ? '1 : alu_ref(m, a, b);
    if (kind != 2) begin
      iss_q.push_back('{m, a, b});
      exp_issued++;
    end
    if (kind != 3) exp_q.push_back(r);
  endtask

  task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b, input int kind);
    int n = 0;
    expect_cmd(m, a, b, kind);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = m;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    while (!bus.cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag);
    int   n = 0;
    rsp_t e;
    bus.rsp_ready = 1'b1;
    while (!bus.rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_expq"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_mode"}, 64'(bus.rsp_mode), 64'(e.mode));
      check({tag, "_data"}, bus.rsp_data, e.data);
      check({tag, "_err"}, 64'(bus.rsp_err), 64'(e.err));
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!bus.alu_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_issue_seen"}, 64'(bus.alu_valid), 64'd1);
  endtask

  initial begin
    int          acc;
    int          n;
    int          snap;
    bit          seen;
    logic [1:0]  m;
    logic [31:0] a;
    logic [31:0] b;

    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    bus.alu_ready = 1'b0;
    bus.alu_out   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_alu_valid", 64'(bus.alu_valid), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", bus.rsp_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // 1: MUL 3*5, with two-cycle issue latency
    expect_cmd(MODE_MUL, 32'd3, 32'd5, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = MODE_MUL;
    bus.cmd_a     = 32'd3;
    bus.cmd_b     = 32'd5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("t1_not_yet", 64'(bus.alu_valid), 64'd0);
    @(negedge clk);
    check("t1_issue_lat", 64'(bus.alu_valid), 64'd1);
    check("t1_issue_a", 64'(bus.alu_a), 64'd3);
    get_rsp("t1");
    check("t1_rsp_drop", 64'(bus.rsp_valid), 64'd0);
    check("t1_const", alu_ref(MODE_MUL, 32'd3, 32'd5), 64'h0F);

    // 2: DIV, SHIFT, AVG with fixed values
    send(MODE_DIV, 32'd100, 32'd7, 0);
    get_rsp("t2_div");
    send(MODE_SHIFT, 32'hF0, 32'd3, 0);
    get_rsp("t2_shift");
    send(MODE_AVG, 32'd6, 32'd9, 0);
    get_rsp("t2_avg");
    check("t2_div_const", alu_ref(MODE_DIV, 32'd100, 32'd7), {32'd2, 32'd14});
    check("t2_avg_const", alu_ref(MODE_AVG, 32'd6, 32'd9), 64'h7);

    // Random commands, one at a time
    for (int i = 0; i < 8; i++) begin
      m = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (m == MODE_DIV && b == 0) b = 32'd1;
      send(m, a, b, 0);
      get_rsp("rand");
    end

    // 3: back-pressure, exactly DEPTH+1 commands absorbed
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      m = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom | 32'd1;
      bus.cmd_valid = 1'b1;
      bus.cmd_mode  = m;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      if (bus.cmd_ready) begin
        expect_cmd(m, a, b, 0);
        acc++;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("t3_accepted", 64'(acc), 64'(DEPTH + 1));
    check("t3_full", 64'(bus.cmd_ready), 64'd0);
    for (int i = 0; i < DEPTH + 1; i++) get_rsp("t3");

    // 4: timeout, then normal operation resumes
    never_ready = 1'b1;
    send(MODE_SHIFT, 32'h55, 32'd1, 1);
    wait_issue("t4");
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_latency", 64'(n), 64'(TIMEOUT + 1));
    get_rsp("t4_to");
    never_ready = 1'b0;
    send(MODE_AVG, 32'd10, 32'd20, 0);
    get_rsp("t4_next");

    // 5: reset during WAIT of a MUL; the late ready must be ignored
    send(MODE_MUL, 32'd7, 32'd9, 3);
    wait_issue("t5");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    rst_n = 1'b1;
    snap = issued;
    seen = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (45) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    bus.rsp_ready = 1'b0;
    check("t5_no_rsp", 64'(seen), 64'd0);
    check("t5_no_issue", 64'(issued - snap), 64'd0);
    check("t5_rsp_data", bus.rsp_data, 64'd0);
    check("t5_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("t5_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    send(MODE_SHIFT, 32'h100, 32'd4, 0);
    get_rsp("t5_next");

    // 6: DIV by zero
    snap = issued;
`ifdef ALU_MASTER_DIV0_GUARD_EN
    send(MODE_DIV, 32'd55, 32'd0, 2);
    get_rsp("t6_guard");
    check("t6_not_issued", 64'(issued - snap), 64'd0);
`else
    send(MODE_DIV, 32'd55, 32'd0, 0);
    get_rsp("t6_div0");
    check("t6_issued", 64'(issued - snap), 64'd1);
`endif

    repeat (3) @(negedge clk);
    check("issue_clean", 64'(bad_issue), 64'd0);
    check("issue_count", 64'(issued), 64'(exp_issued));
    check("exp_drained", 64'(exp_q.size()), 64'd0);
    check("iss_drained", 64'(iss_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
